// File: rtl/ethercat_timer_master.sv
// ethercat_timer_master: Avalon-MM master for the EtherCAT interval-timer slave.
// Loads the period, starts/stops the timer, services its irq and counts ticks.
// Optional counter snapshot path enabled by defining ETHERCAT_TIMER_MASTER_SNAPSHOT_EN.
module ethercat_timer_master #(
    parameter int READ_LATENCY = 1,
    parameter int TICK_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_req,
    input  logic              stop_req,
    input  logic              snap_req,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cfg_irq_en,
    output logic              req_ready,
    output logic              running,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        WR_STOP,
        WR_STATUS
`ifdef ETHERCAT_TIMER_MASTER_SNAPSHOT_EN
        ,
        SNAP_WR,
        SNAP_RD_L,
        SNAP_WT_L,
        SNAP_RD_H,
        SNAP_WT_H
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                rst_done_q;
    // Low period half is written the cycle after acceptance, so only the high half is held.
    logic [15:0]         period_hi_q, period_hi_d;
    logic                cont_q, cont_d;
    logic                irq_en_q, irq_en_d;
    logic                cs_q, cs_d;
    logic                wr_n_q, wr_n_d;
    logic [2:0]          addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                running_q, running_d;
    logic                tick_pulse_q, tick_pulse_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;

`ifdef ETHERCAT_TIMER_MASTER_SNAPSHOT_EN
    logic [1:0]          wait_q, wait_d;
    logic [15:0]         snap_lo_q, snap_lo_d;
    logic [31:0]         snap_value_q, snap_value_d;
    logic                snap_valid_q, snap_valid_d;
    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);
`else
    logic                unused_inputs;
    assign unused_inputs = ^{snap_req, avm_readdata, 2'(READ_LATENCY)};
`endif

    // Requests are held off until one edge after reset release and while an irq is pending.
    assign req_ready      = rst_done_q && (state_q == IDLE) && !timer_irq;
    assign running        = running_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wr_n_q;
    assign avm_writedata  = wdata_q;
    assign tick_pulse     = tick_pulse_q;
    assign tick_count     = tick_cnt_q;
`ifdef ETHERCAT_TIMER_MASTER_SNAPSHOT_EN
    assign snap_value     = snap_value_q;
    assign snap_valid     = snap_valid_q;
`else
    assign snap_value     = 32'h0;
    assign snap_valid     = 1'b0;
`endif

    // Next state plus the bus cycle to present during that next state.
    always_comb begin
        state_d      = state_q;
        period_hi_d  = period_hi_q;
        cont_d       = cont_q;
        irq_en_d     = irq_en_q;
        cs_d         = 1'b0;
        wr_n_d       = 1'b1;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        running_d    = running_q;
        tick_pulse_d = 1'b0;
        tick_cnt_d   = tick_cnt_q;
`ifdef ETHERCAT_TIMER_MASTER_SNAPSHOT_EN
        wait_d       = wait_q;
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rst_done_q) begin
                    if (stop_req) begin
                        state_d = WR_STOP;
                        cs_d    = 1'b1;
                        wr_n_d  = 1'b0;
                        addr_d  = 3'd1;
                        wdata_d = 16'h0008;
                    end else if (timer_irq) begin
                        state_d = WR_STATUS;
                        cs_d    = 1'b1;
                        wr_n_d  = 1'b0;
                        addr_d  = 3'd0;
                        wdata_d = 16'h0000;
                    end else if (start_req) begin
                        state_d     = WR_PL;
                        period_hi_d = cfg_period[31:16];
                        cont_d      = cfg_continuous;
                        irq_en_d    = cfg_irq_en;
                        cs_d        = 1'b1;
                        wr_n_d      = 1'b0;
                        addr_d      = 3'd2;
                        wdata_d     = cfg_period[15:0];
                    end
`ifdef ETHERCAT_TIMER_MASTER_SNAPSHOT_EN
                    else if (snap_req) begin
                        state_d = SNAP_WR;
                        cs_d    = 1'b1;
                        wr_n_d  = 1'b0;
                        addr_d  = 3'd4;
                        wdata_d = 16'h0000;
                    end
`endif
                end
            end
            WR_PL: begin
                state_d = WR_PH;
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = 3'd3;
                wdata_d = period_hi_q;
            end
            WR_PH: begin
                state_d = WR_CTRL;
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = 3'd1;
                wdata_d = {12'h000, 1'b0, 1'b1, cont_q, irq_en_q};
            end
            WR_CTRL: begin
                state_d   = IDLE;
                running_d = 1'b1;
            end
            WR_STOP: begin
                state_d   = IDLE;
                running_d = 1'b0;
            end
            WR_STATUS: begin
                state_d      = IDLE;
                tick_pulse_d = 1'b1;
                tick_cnt_d   = tick_cnt_q + 1'b1;
                if (!cont_q) running_d = 1'b0;
            end
`ifdef ETHERCAT_TIMER_MASTER_SNAPSHOT_EN
            SNAP_WR: begin
                state_d = SNAP_RD_L;
                cs_d    = 1'b1;
                addr_d  = 3'd4;
            end
            SNAP_RD_L: begin
                state_d = SNAP_WT_L;
                wait_d  = WAIT_INIT;
            end
            SNAP_WT_L: begin
                if (wait_q == 2'd0) begin
                    snap_lo_d = avm_readdata;
                    state_d   = SNAP_RD_H;
                    cs_d      = 1'b1;
                    addr_d    = 3'd5;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            SNAP_RD_H: begin
                state_d = SNAP_WT_H;
                wait_d  = WAIT_INIT;
            end
            SNAP_WT_H: begin
                if (wait_q == 2'd0) begin
                    snap_value_d = {avm_readdata, snap_lo_q};
                    snap_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any sequence in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rst_done_q   <= 1'b0;
            period_hi_q  <= 16'h0;
            cont_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            cs_q         <= 1'b0;
            wr_n_q       <= 1'b1;
            addr_q       <= 3'd0;
            wdata_q      <= 16'h0;
            running_q    <= 1'b0;
            tick_pulse_q <= 1'b0;
            tick_cnt_q   <= '0;
`ifdef ETHERCAT_TIMER_MASTER_SNAPSHOT_EN
            wait_q       <= 2'd0;
            snap_lo_q    <= 16'h0;
            snap_value_q <= 32'h0;
            snap_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rst_done_q   <= 1'b1;
            period_hi_q  <= period_hi_d;
            cont_q       <= cont_d;
            irq_en_q     <= irq_en_d;
            cs_q         <= cs_d;
            wr_n_q       <= wr_n_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            running_q    <= running_d;
            tick_pulse_q <= tick_pulse_d;
            tick_cnt_q   <= tick_cnt_d;
`ifdef ETHERCAT_TIMER_MASTER_SNAPSHOT_EN
            wait_q       <= wait_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_ethercat_timer_master.sv
// Directed bench for ethercat_timer_master with a small timer-slave model.
module tb_ethercat_timer_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_req = 1'b0, stop_req = 1'b0, snap_req = 1'b0;
    logic [31:0] cfg_period = 32'h0;
    logic        cfg_continuous = 1'b0, cfg_irq_en = 1'b0;
    logic        req_ready, running;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata = 16'h0;
    logic        timer_irq = 1'b0;
    logic        irq_set = 1'b0;
    logic        tick_pulse;
    logic [31:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;
    int          wr0_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          base0;

    always #5 clk = ~clk;

    ethercat_timer_master #(.READ_LATENCY(1), .TICK_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_req(start_req), .stop_req(stop_req), .snap_req(snap_req),
        .cfg_period(cfg_period), .cfg_continuous(cfg_continuous), .cfg_irq_en(cfg_irq_en),
        .req_ready(req_ready), .running(running),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .timer_irq(timer_irq),
        .tick_pulse(tick_pulse), .tick_count(tick_count),
        .snap_value(snap_value), .snap_valid(snap_valid)
    );

    // Slave model: status write clears irq, reads return registered data one cycle later.
    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n && avm_address == 3'd0) begin
            timer_irq <= 1'b0;
            wr0_cnt   <= wr0_cnt + 1;
        end else if (irq_set) begin
            timer_irq <= 1'b1;
        end
        if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 3'd4) ? 16'h1234 :
                            (avm_address == 3'd5) ? 16'hABCD : 16'h0000;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
        chk({tag, "_cs"}, 32'(avm_chipselect), 32'd1);
        chk({tag, "_wrn"}, 32'(avm_write_n), 32'd0);
        chk({tag, "_addr"}, 32'(avm_address), 32'(a));
        chk({tag, "_data"}, 32'(avm_writedata), 32'(d));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_wrn", 32'(avm_write_n), 32'd1);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_wdata", 32'(avm_writedata), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_tick", tick_count, 32'd0);
        chk("rst_snapv", snap_value, 32'd0);
        chk("rst_snapvld", 32'(snap_valid), 32'd0);
        reset_n = 1'b1;
        cyc();
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Start, continuous with irq enabled
        start_req = 1'b1; cfg_period = 32'h02FAF07F; cfg_continuous = 1'b1; cfg_irq_en = 1'b1;
        cyc(); start_req = 1'b0;
        chk_wr("st_pl", 3'd2, 16'hF07F);
        chk("st_busy", 32'(req_ready), 32'd0);
        cyc(); chk_wr("st_ph", 3'd3, 16'h02FA);
        cyc(); chk_wr("st_ctrl", 3'd1, 16'h0007);
        chk("st_run_early", 32'(running), 32'd0);
        cyc();
        chk("st_cs_idle", 32'(avm_chipselect), 32'd0);
        chk("st_wrn_idle", 32'(avm_write_n), 32'd1);
        chk("st_running", 32'(running), 32'd1);
        chk("st_ready", 32'(req_ready), 32'd1);

        // irq service; a start arriving while irq is pending is dropped
        base0 = wr0_cnt;
        irq_set = 1'b1;
        cyc(); irq_set = 1'b0;
        chk("irq_ready_lo", 32'(req_ready), 32'd0);
        start_req = 1'b1;
        cyc(); start_req = 1'b0;
        chk_wr("irq_wr", 3'd0, 16'h0000);
        cyc();
        chk("irq_pulse", 32'(tick_pulse), 32'd1);
        chk("irq_count", tick_count, 32'd1);
        chk("irq_cleared", 32'(timer_irq), 32'd0);
        chk("irq_cs_idle", 32'(avm_chipselect), 32'd0);
        chk("irq_running", 32'(running), 32'd1);
        cyc();
        chk("irq_pulse_off", 32'(tick_pulse), 32'd0);
        chk("irq_dropped_start", 32'(avm_chipselect), 32'd0);
        chk("irq_one_write", 32'(wr0_cnt - base0), 32'd1);

        // One-shot start, then irq ends the run
        do_reset();
        start_req = 1'b1; cfg_period = 32'h00000010; cfg_continuous = 1'b0; cfg_irq_en = 1'b1;
        cyc(); start_req = 1'b0;
        chk_wr("os_pl", 3'd2, 16'h0010);
        cyc(); chk_wr("os_ph", 3'd3, 16'h0000);
        cyc(); chk_wr("os_ctrl", 3'd1, 16'h0005);
        cyc(); chk("os_running", 32'(running), 32'd1);
        irq_set = 1'b1;
        cyc(); irq_set = 1'b0;
        cyc(); chk_wr("os_irq_wr", 3'd0, 16'h0000);
        cyc();
        chk("os_pulse", 32'(tick_pulse), 32'd1);
        chk("os_stopped", 32'(running), 32'd0);
        chk("os_count", tick_count, 32'd1);
        cyc();

`ifdef ETHERCAT_TIMER_MASTER_SNAPSHOT_EN
        // Snapshot: low/high halves read back and published together
        snap_req = 1'b1;
        cyc(); snap_req = 1'b0;
        chk_wr("sn_wr", 3'd4, 16'h0000);
        cyc();
        chk("sn_rdl_cs", 32'(avm_chipselect), 32'd1);
        chk("sn_rdl_wrn", 32'(avm_write_n), 32'd1);
        chk("sn_rdl_addr", 32'(avm_address), 32'd4);
        cyc(); chk("sn_wtl_cs", 32'(avm_chipselect), 32'd0);
        cyc();
        chk("sn_rdh_cs", 32'(avm_chipselect), 32'd1);
        chk("sn_rdh_wrn", 32'(avm_write_n), 32'd1);
        chk("sn_rdh_addr", 32'(avm_address), 32'd5);
        cyc(); chk("sn_vld_early", 32'(snap_valid), 32'd0);
        cyc();
        chk("sn_valid", 32'(snap_valid), 32'd1);
        chk("sn_value", snap_value, 32'hABCD1234);
        chk("sn_ready", 32'(req_ready), 32'd1);
        cyc();
        chk("sn_valid_off", 32'(snap_valid), 32'd0);
        chk("sn_hold", snap_value, 32'hABCD1234);
`else
        // Snapshot disabled: request ignored, outputs stay zero
        snap_req = 1'b1;
        chk("sn_ready_kept", 32'(req_ready), 32'd1);
        cyc(); snap_req = 1'b0;
        chk("sn_no_cs", 32'(avm_chipselect), 32'd0);
        cyc();
        chk("sn_no_valid", 32'(snap_valid), 32'd0);
        chk("sn_zero", snap_value, 32'd0);
`endif

        // stop and irq in the same IDLE cycle: stop first, then irq service
        start_req = 1'b1; cfg_period = 32'h00000100; cfg_continuous = 1'b1; cfg_irq_en = 1'b0;
        cyc(); start_req = 1'b0;
        cyc(); cyc();
        chk_wr("ps_ctrl", 3'd1, 16'h0006);
        cyc(); chk("ps_running", 32'(running), 32'd1);
        base0 = wr0_cnt;
        irq_set = 1'b1;
        cyc(); irq_set = 1'b0;
        stop_req = 1'b1;
        cyc(); stop_req = 1'b0;
        chk_wr("ps_stop", 3'd1, 16'h0008);
        chk("ps_irq_held", 32'(timer_irq), 32'd1);
        cyc();
        chk("ps_stopped", 32'(running), 32'd0);
        chk("ps_gap_cs", 32'(avm_chipselect), 32'd0);
        cyc(); chk_wr("ps_irq_wr", 3'd0, 16'h0000);
        cyc();
        chk("ps_pulse", 32'(tick_pulse), 32'd1);
        chk("ps_count", tick_count, 32'd2);
        chk("ps_one_write", 32'(wr0_cnt - base0), 32'd1);
        cyc();

        // Reset in the middle of a start sequence
        start_req = 1'b1; cfg_period = 32'h12345678; cfg_continuous = 1'b1; cfg_irq_en = 1'b1;
        cyc(); start_req = 1'b0;
        cyc(); chk_wr("rm_ph", 3'd3, 16'h1234);
        reset_n = 1'b0;
        cyc();
        chk("rm_cs", 32'(avm_chipselect), 32'd0);
        chk("rm_addr", 32'(avm_address), 32'd0);
        chk("rm_count", tick_count, 32'd0);
        chk("rm_running", 32'(running), 32'd0);
        reset_n = 1'b1;
        cyc(); chk("rm_no_ctrl1", 32'(avm_chipselect), 32'd0);
        cyc(); chk("rm_no_ctrl2", 32'(avm_chipselect), 32'd0);
        chk("rm_run_after", 32'(running), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
